// File: rtl/vote_pkg.sv
// Shared types and constants for the vote result reporter: FSM states,
// record tags and winner-id encodings.
package vote_pkg;

  localparam int CNT_W_DEF = 32;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_CAPTURE = 3'd1,
    ST_CMP1    = 3'd2,
    ST_CMP2    = 3'd3,
    ST_SEND    = 3'd4,
    ST_DONE    = 3'd5
  } state_t;

  localparam logic [1:0] TAG_CAND1 = 2'd0;
  localparam logic [1:0] TAG_CAND2 = 2'd1;
  localparam logic [1:0] TAG_CAND3 = 2'd2;
  localparam logic [1:0] TAG_WIN   = 2'd3;

  // Winner ids; id 0 is reserved to mean "tie, no single winner".
  localparam logic [1:0] WIN_TIE = 2'd0;
  localparam logic [1:0] ID_C1   = 2'd1;
  localparam logic [1:0] ID_C2   = 2'd2;
  localparam logic [1:0] ID_C3   = 2'd3;

endpackage

// File: rtl/vote_max2.sv
// Combinational max of two (id, count) pairs plus an equality flag.
// On equal counts pair a is returned; callers use eq to flag the tie.
module vote_max2 import vote_pkg::*; #(
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic [1:0]       a_id,
  input  logic [CNT_W-1:0] a_cnt,
  input  logic [1:0]       b_id,
  input  logic [CNT_W-1:0] b_cnt,
  output logic [1:0]       max_id,
  output logic [CNT_W-1:0] max_cnt,
  output logic             eq
);

  always_comb begin
    eq      = (a_cnt == b_cnt);
    max_id  = a_id;
    max_cnt = a_cnt;
    if (b_cnt > a_cnt) begin
      max_id  = b_id;
      max_cnt = b_cnt;
    end
  end

endmodule

// File: rtl/vote_result_reporter.sv
// Snapshots three candidate tallies when voting closes, finds the winner with
// a shared 2-input max unit, and streams four valid/ready records.
module vote_result_reporter import vote_pkg::*; #(
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_voting_over,
  input  logic [CNT_W-1:0] i_count1,
  input  logic [CNT_W-1:0] i_count2,
  input  logic [CNT_W-1:0] i_count3,
  output logic             o_valid,
  input  logic             i_ready,
  output logic [1:0]       o_tag,
  output logic [CNT_W-1:0] o_data,
  output logic             o_busy,
  output logic             o_done,
  output logic [2:0]       o_state
);

  // Handshake: a record moves on a rising clk edge where o_valid && i_ready.
  // o_valid is a register, never a function of i_ready; once raised it holds
  // with o_tag/o_data stable until accepted.

  state_t state, state_nxt;

  logic             prev_vo;
  logic [CNT_W-1:0] snap1, snap2, snap3;
  logic [1:0]       best_id;
  logic [CNT_W-1:0] best_cnt;
  logic             tie;

  logic [1:0]       cmp_a_id, cmp_b_id, m_id;
  logic [CNT_W-1:0] cmp_a_cnt, cmp_b_cnt, m_cnt;
  logic             m_eq;
  logic             tie_win;

  logic [1:0]       load_tag;
  logic [CNT_W-1:0] rec_data;
  logic [CNT_W-1:0] win_word;
  logic             load_rec;
  logic             last_acc;

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nxt;
  end

  // Next state and status outputs
  always_comb begin
    state_nxt = state;
    o_busy    = 1'b0;
    o_done    = 1'b0;
    case (state)
      ST_IDLE: begin
        if (i_voting_over && !prev_vo) state_nxt = ST_CAPTURE;
      end
      ST_CAPTURE: begin
        o_busy    = 1'b1;
        state_nxt = ST_CMP1;
      end
      ST_CMP1: begin
        o_busy    = 1'b1;
        state_nxt = ST_CMP2;
      end
      ST_CMP2: begin
        o_busy    = 1'b1;
        state_nxt = ST_SEND;
      end
      ST_SEND: begin
        o_busy = 1'b1;
        if (last_acc) state_nxt = ST_DONE;
      end
      ST_DONE: begin
        o_done = 1'b1;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  assign o_state = state;

  // The single max unit serves both compare steps.
  always_comb begin
    cmp_a_id  = ID_C1;
    cmp_a_cnt = snap1;
    cmp_b_id  = ID_C2;
    cmp_b_cnt = snap2;
    if (state == ST_CMP2) begin
      cmp_a_id  = best_id;
      cmp_a_cnt = best_cnt;
      cmp_b_id  = ID_C3;
      cmp_b_cnt = snap3;
    end
  end

  vote_max2 #(.CNT_W(CNT_W)) u_max2 (
    .a_id    (cmp_a_id),
    .a_cnt   (cmp_a_cnt),
    .b_id    (cmp_b_id),
    .b_cnt   (cmp_b_cnt),
    .max_id  (m_id),
    .max_cnt (m_cnt),
    .eq      (m_eq)
  );

  // A tie with candidate 3, or an earlier tie that candidate 3 did not beat.
  assign tie_win = m_eq || (tie && (m_id != ID_C3));

  assign win_word = {{(CNT_W-3){1'b0}}, tie, best_id};
  assign last_acc = o_valid && i_ready && (o_tag == TAG_WIN);
  assign load_rec = (state == ST_SEND) && !last_acc && (!o_valid || i_ready);
  assign load_tag = o_valid ? (o_tag + 2'd1) : TAG_CAND1;

  always_comb begin
    rec_data = win_word;
    case (load_tag)
      TAG_CAND1: rec_data = snap1;
      TAG_CAND2: rec_data = snap2;
      TAG_CAND3: rec_data = snap3;
      default:   rec_data = win_word;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      prev_vo  <= 1'b0;
      snap1    <= '0;
      snap2    <= '0;
      snap3    <= '0;
      best_id  <= WIN_TIE;
      best_cnt <= '0;
      tie      <= 1'b0;
      o_valid  <= 1'b0;
      o_tag    <= TAG_CAND1;
      o_data   <= '0;
    end else begin
      prev_vo <= i_voting_over;
      case (state)
        ST_CAPTURE: begin
          snap1 <= i_count1;
          snap2 <= i_count2;
          snap3 <= i_count3;
        end
        ST_CMP1: begin
          best_id  <= m_id;
          best_cnt <= m_cnt;
          tie      <= m_eq;
        end
        ST_CMP2: begin
          best_id  <= tie_win ? WIN_TIE : m_id;
          best_cnt <= m_cnt;
          tie      <= tie_win;
        end
        ST_SEND: begin
          if (last_acc) begin
            o_valid <= 1'b0;
          end else if (load_rec) begin
            o_valid <= 1'b1;
            o_tag   <= load_tag;
            o_data  <= rec_data;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_vote_result_reporter.sv
// Directed and randomized elections against a max/tie-count reference model.
module tb_vote_result_reporter;

  localparam int CNT_W = 32;
  localparam int W     = CNT_W + 2;

  logic             clk = 1'b0;
  logic             rst;
  logic             i_voting_over;
  logic [CNT_W-1:0] i_count1, i_count2, i_count3;
  logic             o_valid;
  logic             i_ready;
  logic [1:0]       o_tag;
  logic [CNT_W-1:0] o_data;
  logic             o_busy;
  logic             o_done;
  logic [2:0]       o_state;

  int n_vec = 0;
  int n_err = 0;
  logic [W-1:0] exp_q[$];

  vote_result_reporter #(.CNT_W(CNT_W)) dut (
    .clk           (clk),
    .rst           (rst),
    .i_voting_over (i_voting_over),
    .i_count1      (i_count1),
    .i_count2      (i_count2),
    .i_count3      (i_count3),
    .o_valid       (o_valid),
    .i_ready       (i_ready),
    .o_tag         (o_tag),
    .o_data        (o_data),
    .o_busy        (o_busy),
    .o_done        (o_done),
    .o_state       (o_state)
  );

  // Clock / reset helpers
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [CNT_W-1:0] obs, input logic [CNT_W-1:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference: winner is the unique maximum; any shared maximum is a tie (0x4).
  function automatic logic [CNT_W-1:0] ref_win(input logic [CNT_W-1:0] c1, c2, c3);
    logic [CNT_W-1:0] m;
    int n;
    m = c1;
    if (c2 > m) m = c2;
    if (c3 > m) m = c3;
    n = int'(c1 == m) + int'(c2 == m) + int'(c3 == m);
    if (n > 1)        return 32'h4;
    else if (c1 == m) return 32'h1;
    else if (c2 == m) return 32'h2;
    else              return 32'h3;
  endfunction

  task automatic load_exp(input logic [CNT_W-1:0] c1, c2, c3);
    exp_q.delete();
    exp_q.push_back({2'd0, c1});
    exp_q.push_back({2'd1, c2});
    exp_q.push_back({2'd2, c3});
    exp_q.push_back({2'd3, ref_win(c1, c2, c3)});
  endtask

  task automatic do_reset();
    i_voting_over = 1'b0;
    rst = 1'b1;
    #2;
    check("rst_valid", o_valid, 0);
    check("rst_tag",   o_tag,   0);
    check("rst_data",  o_data,  0);
    check("rst_busy",  o_busy,  0);
    check("rst_done",  o_done,  0);
    check("rst_state", o_state, vote_pkg::ST_IDLE);
    @(negedge clk);
    rst = 1'b0;
    tick();
  endtask

  // rdy_mode: 0 = ready tied high, 1 = fixed 1,0,0,1,0,1,1 pattern, 2 = random
  task automatic run_election(input logic [CNT_W-1:0] c1, c2, c3, input int rdy_mode,
                              input int stop_after, input bit change_counts);
    bit pat [0:6];
    int xfers, cycles, k;
    logic hv;
    logic [1:0] ht;
    logic [CNT_W-1:0] hd;
    logic [W-1:0] e;
    bit rdy;
    pat = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
    xfers = 0; cycles = 0; k = 0;
    load_exp(c1, c2, c3);
    i_count1 = c1; i_count2 = c2; i_count3 = c3;
    i_ready = 1'b1;
    i_voting_over = 1'b1;
    tick();
    check("capture_busy",  o_busy,  1);
    check("capture_valid", o_valid, 0);
    tick();
    if (change_counts) begin
      i_count1 = 100; i_count2 = 0; i_count3 = 0;
    end
    i_voting_over = 1'b0;
    tick();
    tick();
    check("latency_early", o_valid, 0);
    i_voting_over = 1'b1;
    tick();
    check("latency", o_valid, 1);
    while (exp_q.size() > 0 && xfers < stop_after && cycles < 40) begin
      check("valid_held", o_valid, 1);
      hv = o_valid; ht = o_tag; hd = o_data;
      case (rdy_mode)
        0:       rdy = 1'b1;
        1:       rdy = (k < 7) ? pat[k] : 1'b1;
        default: rdy = 1'($urandom_range(0, 1));
      endcase
      k++;
      i_ready = rdy;
      tick();
      cycles++;
      if (hv && rdy) begin
        e = exp_q.pop_front();
        check("rec_tag",  ht, e[W-1:CNT_W]);
        check("rec_data", hd, e[CNT_W-1:0]);
        xfers++;
      end else if (hv) begin
        check("stall_tag",  o_tag,  ht);
        check("stall_data", o_data, hd);
      end
    end
    if (stop_after >= 4) begin
      check("xfer_count", xfers, 4);
      if (rdy_mode == 0) check("b2b_cycles", cycles, 4);
      check("done",       o_done,  1);
      check("done_valid", o_valid, 0);
      check("done_busy",  o_busy,  0);
    end
  endtask

  initial begin
    rst = 1'b1;
    i_voting_over = 1'b0;
    i_ready = 1'b0;
    i_count1 = '0; i_count2 = '0; i_count3 = '0;
    do_reset();

    run_election(5, 9, 2, 0, 4, 1'b0);
    i_voting_over = 1'b0;
    tick();
    i_voting_over = 1'b1;
    for (int i = 0; i < 8; i++) begin
      tick();
      check("done_ignore_valid", o_valid, 0);
      check("done_hold",         o_done,  1);
    end

    do_reset();
    run_election(7, 3, 7, 0, 4, 1'b0);
    do_reset();
    run_election(0, 0, 0, 0, 4, 1'b0);
    do_reset();
    run_election(1, 2, 3, 1, 4, 1'b0);
    do_reset();
    run_election(4, 4, 9, 0, 4, 1'b1);

    do_reset();
    run_election(1, 0, 0, 0, 2, 1'b0);
    do_reset();
    for (int i = 0; i < 6; i++) begin
      tick();
      check("idle_no_edge_valid", o_valid, 0);
      check("idle_no_edge_busy",  o_busy,  0);
    end
    run_election(1, 0, 0, 0, 4, 1'b0);

    for (int n = 0; n < 16; n++) begin
      logic [CNT_W-1:0] a, b, c;
      if (n % 2 == 0) begin
        a = $urandom_range(0, 3); b = $urandom_range(0, 3); c = $urandom_range(0, 3);
      end else begin
        a = $urandom; b = $urandom; c = $urandom;
      end
      do_reset();
      run_election(a, b, c, 2, 4, 1'b0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
